// File: rtl/hpf_sched_pkg.sv
// rtl/hpf_sched_pkg.sv - shared types and defaults for the HPF multiplier scheduler
// Contents:
//   DEF_N_CH, DEF_MULT_LAT : default channel count and multiplier latency
//   IDX_MAX_W              : widest channel index the tag can carry (16 channels)
//   state_t                : scheduler FSM states
//   wb_tag_t               : write-back tag {valid, idx, clr} carried down the delay line
package hpf_sched_pkg;

    localparam int DEF_N_CH     = 8;
    localparam int DEF_MULT_LAT = 1;
    localparam int IDX_MAX_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
        logic                 clr;
    } wb_tag_t;

endpackage

// File: rtl/hpf_mult_scheduler_if.sv
// rtl/hpf_mult_scheduler_if.sv - control/status bundle between sequencer, scheduler and HPF storage
// Signals:
//   frame_start, ch_enable, hold, clear_req : driven by the surrounding sequencer (master)
//   mult_sel, issue_valid                   : multiplier input mux select and strobe
//   wb_valid, wb_ch, wb_clear               : HPF state write-back strobe, index, zero-load
//   busy, done, overrun_cnt                 : frame status
// Modports: master (sequencer side), slave (scheduler side).
interface hpf_mult_scheduler_if #(
    parameter int N_CH  = 8,
    parameter int IDX_W = $clog2(N_CH)
);
    logic             frame_start;
    logic [N_CH-1:0]  ch_enable;
    logic             hold;
    logic [N_CH-1:0]  clear_req;
    logic [IDX_W-1:0] mult_sel;
    logic             issue_valid;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_ch;
    logic             wb_clear;
    logic             busy;
    logic             done;
    logic [7:0]       overrun_cnt;

    modport master (
        output frame_start, ch_enable, hold, clear_req,
        input  mult_sel, issue_valid, wb_valid, wb_ch, wb_clear, busy, done, overrun_cnt
    );

    modport slave (
        input  frame_start, ch_enable, hold, clear_req,
        output mult_sel, issue_valid, wb_valid, wb_ch, wb_clear, busy, done, overrun_cnt
    );
endinterface

// File: rtl/hpf_mult_scheduler_wb_delay_line.sv
// rtl/hpf_mult_scheduler_wb_delay_line.sv - DEPTH-stage shift register for write-back tags
// Ports:
//   clk, rst : clock, asynchronous active-high reset (flushes every stage)
//   tag_i    : tag entering the pipeline this cycle
//   tag_o    : registered tag leaving the last stage
module wb_delay_line
    import hpf_sched_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  wb_tag_t tag_i,
    output wb_tag_t tag_o
);
    wb_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hpf_mult_scheduler.sv
// rtl/hpf_mult_scheduler.sv - time-shares one HPF multiplier across N_CH channels per frame
// Ports:
//   dataclk : system clock
//   reset   : asynchronous active-high reset
//   bus     : hpf_mult_scheduler_if.slave (frame control in, issue/write-back/status out)
// Parameters: N_CH (2..16), MULT_LAT (1..4), IDX_W (channel index width).
module hpf_mult_scheduler
    import hpf_sched_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int IDX_W    = $clog2(N_CH)
) (
    input  logic                  dataclk,
    input  logic                  reset,
    hpf_mult_scheduler_if.slave   bus
);
    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       drain_q;
    logic [N_CH-1:0]  pending_clr_q, pending_clr_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             issue;
    wb_tag_t          tag_in, tag_out;
    logic             wb_idx_unused;

    // A disabled channel still burns its slot; only the strobe is suppressed.
    assign issue = (state_q == ISSUE) && bus.ch_enable[idx_q] && !bus.hold;

    // A request arriving in the same cycle as the issue is OR-ed in after the
    // consume, so it survives to the next frame instead of being swallowed.
    always_comb begin
        pending_clr_d = pending_clr_q;
        if (issue) begin
            pending_clr_d[idx_q] = 1'b0;
        end
        pending_clr_d = pending_clr_d | bus.clear_req;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (bus.frame_start && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.idx   = IDX_MAX_W'(idx_q);
        tag_in.clr   = issue & pending_clr_q[idx_q];
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        state_q <= ISSUE;
                        idx_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (!bus.hold) begin
                        if (idx_q == IDX_W'(N_CH - 1)) begin
                            state_q <= DRAIN;
                            idx_q   <= '0;
                            drain_q <= 2'(MULT_LAT - 1);
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            pending_clr_q <= '0;
            overrun_q     <= '0;
        end else begin
            pending_clr_q <= pending_clr_d;
            overrun_q     <= overrun_d;
        end
    end

    // Tags shift every cycle regardless of hold so issued products write back on time.
    wb_delay_line #(
        .DEPTH (MULT_LAT)
    ) u_wb_delay_line (
        .clk   (dataclk),
        .rst   (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Upper tag index bits are zero for narrower channel counts.
    assign wb_idx_unused = ^tag_out.idx;

    assign bus.mult_sel    = idx_q;
    assign bus.issue_valid = issue;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.overrun_cnt = overrun_q;
    assign bus.wb_valid    = tag_out.valid;
    assign bus.wb_ch       = tag_out.idx[IDX_W-1:0];
    assign bus.wb_clear    = tag_out.valid & tag_out.clr;

endmodule

// File: tb/tb_hpf_mult_scheduler.sv
// tb/tb_hpf_mult_scheduler.sv - directed self-checking bench for hpf_mult_scheduler
module tb_hpf_mult_scheduler;

    localparam int NCAP = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hpf_mult_scheduler_if #(.N_CH(8)) b8 ();
    hpf_mult_scheduler_if #(.N_CH(8)) b3 ();

    hpf_mult_scheduler #(.N_CH(8), .MULT_LAT(1)) dut8 (
        .dataclk (clk),
        .reset   (rst),
        .bus     (b8)
    );

    hpf_mult_scheduler #(.N_CH(8), .MULT_LAT(3)) dut3 (
        .dataclk (clk),
        .reset   (rst),
        .bus     (b3)
    );

    logic       cap_iv   [NCAP];
    logic [2:0] cap_sel  [NCAP];
    logic       cap_wbv  [NCAP];
    logic [2:0] cap_wbch [NCAP];
    logic       cap_wbclr[NCAP];
    logic       cap_done [NCAP];
    logic       cap_busy [NCAP];

    // Starts a frame on the chosen DUT and records NCAP cycles from cycle 0.
    task automatic run_frame(input bit use3, input logic [7:0] en, input int hl, input int hh,
                             input int clr_cyc);
        if (use3) begin
            b3.ch_enable = en; b3.frame_start = 1'b1;
        end else begin
            b8.ch_enable = en; b8.frame_start = 1'b1;
        end
        @(posedge clk); #1;
        b8.frame_start = 1'b0;
        b3.frame_start = 1'b0;
        for (int c = 0; c < NCAP; c++) begin
            if (use3) begin
                b3.hold      = (c >= hl && c <= hh);
                b3.clear_req = (c == clr_cyc) ? 8'h10 : 8'h00;
            end else begin
                b8.hold      = (c >= hl && c <= hh);
                b8.clear_req = (c == clr_cyc) ? 8'h10 : 8'h00;
            end
            @(negedge clk);
            if (use3) begin
                cap_iv[c] = b3.issue_valid; cap_sel[c] = b3.mult_sel; cap_wbv[c] = b3.wb_valid;
                cap_wbch[c] = b3.wb_ch; cap_wbclr[c] = b3.wb_clear; cap_done[c] = b3.done;
                cap_busy[c] = b3.busy;
            end else begin
                cap_iv[c] = b8.issue_valid; cap_sel[c] = b8.mult_sel; cap_wbv[c] = b8.wb_valid;
                cap_wbch[c] = b8.wb_ch; cap_wbclr[c] = b8.wb_clear; cap_done[c] = b8.done;
                cap_busy[c] = b8.busy;
            end
            @(posedge clk); #1;
        end
        b8.hold = 1'b0; b8.clear_req = '0;
        b3.hold = 1'b0; b3.clear_req = '0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({b8.mult_sel, b8.issue_valid, b8.wb_valid, b8.wb_ch, b8.wb_clear, b8.busy, b8.done,
             b8.overrun_cnt} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs8 got %h want 0", {b8.mult_sel, b8.issue_valid,
                     b8.wb_valid, b8.wb_ch, b8.wb_clear, b8.busy, b8.done, b8.overrun_cnt});
        end
        vectors++;
        if ({b3.mult_sel, b3.issue_valid, b3.wb_valid, b3.wb_ch, b3.wb_clear, b3.busy, b3.done,
             b3.overrun_cnt} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs3 got %h want 0", {b3.mult_sel, b3.issue_valid,
                     b3.wb_valid, b3.wb_ch, b3.wb_clear, b3.busy, b3.done, b3.overrun_cnt});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic ev, ew;
        run_frame(1'b0, 8'hFF, 99, 99, -1);
        for (int c = 0; c < NCAP; c++) begin
            ev = (c <= 7);
            ew = (c >= 1 && c <= 8);
            vectors++;
            if (cap_iv[c] !== ev) begin
                miscompares++; $display("FAIL basic_iv c=%0d got %b want %b", c, cap_iv[c], ev);
            end
            if (ev) begin
                vectors++;
                if (cap_sel[c] !== 3'(c)) begin
                    miscompares++; $display("FAIL basic_sel c=%0d got %0d want %0d", c, cap_sel[c], c);
                end
            end
            vectors++;
            if (cap_wbv[c] !== ew) begin
                miscompares++; $display("FAIL basic_wbv c=%0d got %b want %b", c, cap_wbv[c], ew);
            end
            if (ew) begin
                vectors++;
                if (cap_wbch[c] !== 3'(c - 1)) begin
                    miscompares++; $display("FAIL basic_wbch c=%0d got %0d want %0d", c, cap_wbch[c], c - 1);
                end
            end
            vectors++;
            if (cap_done[c] !== (c == 9)) begin
                miscompares++; $display("FAIL basic_done c=%0d got %b want %b", c, cap_done[c], c == 9);
            end
            vectors++;
            if (cap_busy[c] !== (c <= 9)) begin
                miscompares++; $display("FAIL basic_busy c=%0d got %b want %b", c, cap_busy[c], c <= 9);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] en;
        logic ev, ew;
        en = 8'b1010_0101;
        run_frame(1'b0, en, 99, 99, -1);
        for (int c = 0; c < NCAP; c++) begin
            ev = (c <= 7) && en[c[2:0]];
            ew = (c >= 1 && c <= 8) && en[3'(c - 1)];
            vectors++;
            if (cap_iv[c] !== ev) begin
                miscompares++; $display("FAIL en_iv c=%0d got %b want %b", c, cap_iv[c], ev);
            end
            vectors++;
            if (cap_wbv[c] !== ew) begin
                miscompares++; $display("FAIL en_wbv c=%0d got %b want %b", c, cap_wbv[c], ew);
            end
            if (ew) begin
                vectors++;
                if (cap_wbch[c] !== 3'(c - 1)) begin
                    miscompares++; $display("FAIL en_wbch c=%0d got %0d want %0d", c, cap_wbch[c], c - 1);
                end
            end
            vectors++;
            if (cap_done[c] !== (c == 9)) begin
                miscompares++; $display("FAIL en_done c=%0d got %b want %b", c, cap_done[c], c == 9);
            end
        end
    endtask

    task automatic test_hold();
        int  exp_sel [10] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
        bit  exp_iv  [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        logic ew;
        run_frame(1'b0, 8'hFF, 3, 4, -1);
        for (int c = 0; c < NCAP; c++) begin
            if (c <= 9) begin
                vectors++;
                if (cap_sel[c] !== 3'(exp_sel[c])) begin
                    miscompares++; $display("FAIL hold_sel c=%0d got %0d want %0d", c, cap_sel[c], exp_sel[c]);
                end
            end
            vectors++;
            if (cap_iv[c] !== ((c <= 10) ? exp_iv[c] : 1'b0)) begin
                miscompares++; $display("FAIL hold_iv c=%0d got %b", c, cap_iv[c]);
            end
            ew = (c >= 1 && c <= 11) ? exp_iv[c - 1] : 1'b0;
            vectors++;
            if (cap_wbv[c] !== ew) begin
                miscompares++; $display("FAIL hold_wbv c=%0d got %b want %b", c, cap_wbv[c], ew);
            end
            if (ew) begin
                vectors++;
                if (cap_wbch[c] !== 3'(exp_sel[c - 1])) begin
                    miscompares++; $display("FAIL hold_wbch c=%0d got %0d want %0d", c, cap_wbch[c], exp_sel[c - 1]);
                end
            end
            vectors++;
            if (cap_done[c] !== (c == 11)) begin
                miscompares++; $display("FAIL hold_done c=%0d got %b want %b", c, cap_done[c], c == 11);
            end
            vectors++;
            if (cap_busy[c] !== (c <= 11)) begin
                miscompares++; $display("FAIL hold_busy c=%0d got %b want %b", c, cap_busy[c], c <= 11);
            end
        end
    endtask

    task automatic test_clear();
        b8.clear_req = 8'h10;
        @(posedge clk); #1;
        b8.clear_req = 8'h00;
        // Frame 1 consumes the IDLE request; a re-request in channel 4's issue cycle (cycle 4) must survive.
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 8'hFF, 99, 99, (f == 0) ? 4 : -1);
            for (int c = 0; c < NCAP; c++) begin
                vectors++;
                if (cap_wbclr[c] !== (f < 2 && c == 5)) begin
                    miscompares++;
                    $display("FAIL clear_wbclr f=%0d c=%0d got %b want %b", f, c, cap_wbclr[c], f < 2 && c == 5);
                end
            end
            vectors++;
            if (cap_wbch[5] !== 3'd4) begin
                miscompares++; $display("FAIL clear_wbch f=%0d got %0d want 4", f, cap_wbch[5]);
            end
        end
    endtask

    task automatic test_lat3();
        logic ew;
        run_frame(1'b1, 8'hFF, 99, 99, -1);
        for (int c = 0; c < NCAP; c++) begin
            ew = (c >= 3 && c <= 10);
            vectors++;
            if (cap_iv[c] !== (c <= 7)) begin
                miscompares++; $display("FAIL lat3_iv c=%0d got %b want %b", c, cap_iv[c], c <= 7);
            end
            vectors++;
            if (cap_wbv[c] !== ew) begin
                miscompares++; $display("FAIL lat3_wbv c=%0d got %b want %b", c, cap_wbv[c], ew);
            end
            if (ew) begin
                vectors++;
                if (cap_wbch[c] !== 3'(c - 3)) begin
                    miscompares++; $display("FAIL lat3_wbch c=%0d got %0d want %0d", c, cap_wbch[c], c - 3);
                end
            end
            vectors++;
            if (cap_done[c] !== (c == 11)) begin
                miscompares++; $display("FAIL lat3_done c=%0d got %b want %b", c, cap_done[c], c == 11);
            end
            vectors++;
            if (cap_busy[c] !== (c <= 11)) begin
                miscompares++; $display("FAIL lat3_busy c=%0d got %b want %b", c, cap_busy[c], c <= 11);
            end
        end
    endtask

    task automatic test_overrun_reset();
        bit seen;
        b8.ch_enable   = 8'hFF;
        b8.frame_start = 1'b1;
        @(posedge clk); #1;
        b8.hold = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (i == 254 || i == 255 || i == 300) begin
                vectors++;
                if (b8.overrun_cnt !== 8'((i > 255) ? 255 : i)) begin
                    miscompares++;
                    $display("FAIL overrun_cnt i=%0d got %0d want %0d", i, b8.overrun_cnt, (i > 255) ? 255 : i);
                end
            end
        end
        vectors++;
        if ({b8.busy, b8.mult_sel, b8.issue_valid} !== 5'b1_000_0) begin
            miscompares++;
            $display("FAIL overrun_held got %b want 10000", {b8.busy, b8.mult_sel, b8.issue_valid});
        end
        b8.frame_start = 1'b0;
        b8.hold        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({b8.mult_sel, b8.wb_valid, b8.wb_ch} !== 7'b011_1_010) begin
            miscompares++;
            $display("FAIL pre_reset got %b want 0111010", {b8.mult_sel, b8.wb_valid, b8.wb_ch});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({b8.mult_sel, b8.issue_valid, b8.wb_valid, b8.wb_ch, b8.wb_clear, b8.busy, b8.done,
             b8.overrun_cnt} !== 18'd0) begin
            miscompares++;
            $display("FAIL midframe_reset got %h want 0", {b8.mult_sel, b8.issue_valid, b8.wb_valid,
                     b8.wb_ch, b8.wb_clear, b8.busy, b8.done, b8.overrun_cnt});
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (b8.wb_valid || b8.busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_activity got %b want 0", seen);
        end
    endtask

    initial begin
        b8.frame_start = 1'b0; b8.ch_enable = '0; b8.hold = 1'b0; b8.clear_req = '0;
        b3.frame_start = 1'b0; b3.ch_enable = '0; b3.hold = 1'b0; b3.clear_req = '0;
        test_reset();
        test_basic();
        test_enable();
        test_hold();
        test_clear();
        test_lat3();
        test_overrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hpf_mult_scheduler.md
# hpf_mult_scheduler

Frame-synchronous scheduler that time-shares one 18x18 high-pass-filter multiplier (`multiplier_18x18`) across N_CH DAC channels. Once per sample frame it steps a channel index through every channel, issues multiplier operations for enabled channels, and emits index-tagged write-back strobes aligned to the multiplier latency so each channel's HPF state register updates in turn. It also tracks per-channel state-clear requests and counts frames lost to overrun. It sits between the main-state sequencer (frame strobe) and the per-channel HPF state storage / DAC SPI output logic.

## Interface
- N_CH, 8, number of DAC channels; must be 2..16
- MULT_LAT, 1, multiplier input-to-product latency in cycles; must be 1..4
- IDX_W, $clog2(N_CH), channel index width
- dataclk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of sample frame (main_state at ms_clk1_a, channel 0)
- ch_enable  in  N_CH  per-channel DAC enable; sampled in each issue cycle
- hold  in  1  freezes index advance while high
- clear_req  in  N_CH  per-channel pulse requesting HPF state clear
- mult_sel  out  IDX_W  channel select for multiplier input mux
- issue_valid  out  1  multiplier inputs valid this cycle
- wb_valid  out  1  product for wb_ch valid this cycle; write HPF state
- wb_ch  out  IDX_W  channel index of current write-back
- wb_clear  out  1  with wb_valid: load zero instead of new state
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of frame
- overrun_cnt  out  8  frames dropped since reset, saturating at 255

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: frame_start=1 -> ISSUE, idx<=0.
- ISSUE: mult_sel=idx; issue_valid=ch_enable[idx] & ~hold. If hold=1, idx holds. Otherwise idx==N_CH-1 -> DRAIN (drain counter <= MULT_LAT-1), else idx<=idx+1.
- Disabled channel occupies its slot with no issue; frame length is fixed, not data dependent.
- DRAIN: counts down MULT_LAT cycles; at count 0 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Write-back pipeline: MULT_LAT-deep shift register of {valid, idx, clr}. Shifts every cycle, including during hold. Output stage drives wb_valid, wb_ch, wb_clear.
- Clear tracking: pending_clr |= clear_req every cycle. On an issue for channel i, clr=pending_clr[i] enters the pipeline and pending_clr[i] clears. If clear_req[i] is asserted in the same cycle as that issue, the bit stays set for the next frame. Clears for disabled channels remain pending.
- Overrun: frame_start while state != IDLE (including DONE) is ignored and overrun_cnt increments, saturating at 255.
- Outputs mult_sel, issue_valid, and busy decode from registered state. wb_* outputs are registered pipeline outputs.

## Timing
- Cycle 0 is the first cycle after the edge that samples frame_start. With no hold, ISSUE occupies cycles 0..N_CH-1.
- An issue in cycle c produces wb_valid in cycle c+MULT_LAT.
- DRAIN occupies cycles N_CH..N_CH+MULT_LAT-1. done is high in cycle N_CH+MULT_LAT.
- Each held cycle shifts ISSUE, DRAIN and done one cycle later. Write-backs of already-issued ops are not delayed.
- The earliest accepted next frame_start is sampled in the cycle after done.
- Reset (asynchronous, any state including mid-frame): state=IDLE, idx=0, pipeline flushed, pending_clr=0, overrun_cnt=0. All outputs are 0 (mult_sel=0). In-flight write-backs are discarded.

## Structure
- Shared package hpf_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), default N_CH/MULT_LAT constants, write-back tag struct {valid, idx, clr}.
- One sub-module: wb_delay_line (parameterised MULT_LAT-deep tag shift register with asynchronous reset).
- Multiplier and HPF state storage are outside this block.

## Test plan
- N_CH=8, MULT_LAT=1, all enabled, single frame_start -> issue_valid cycles 0..7 with mult_sel 0..7; wb_valid cycles 1..8 with wb_ch 0..7; done in cycle 9; busy low in cycle 10.
- ch_enable=8'b1010_0101 -> issues and write-backs only for channels 0, 2, 5, 7; done timing unchanged (cycle 9).
- hold high in cycles 3-4 -> mult_sel=3 for cycles 3-5; issue at 2 still writes back in cycle 3; done moves to cycle 11.
- clear_req[4] pulsed in IDLE -> wb_clear=1 only with wb_ch=4. Second clear_req[4] in channel 4's issue cycle -> wb_clear=1 for channel 4 again on the next frame.
- frame_start repeated mid-frame 300 times -> frames ignored, overrun_cnt saturates at 255; reset asserted mid-ISSUE -> all outputs 0 immediately, no further wb_valid.
- MULT_LAT=3 -> wb_valid cycles 3..10, DRAIN cycles 8..10, done in cycle 11.
